// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result stage:
//   - the 12 one-hot opcode select constants (bit 11 = CLEAR)
//   - flag bit indices inside the 4-bit {ERR,CLR,N,Z} flag word
//   - the packed flags struct
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam int unsigned NUM_OPS = 12;

   localparam logic [NUM_OPS-1:0] OP_AND     = 12'h001;
   localparam logic [NUM_OPS-1:0] OP_OR      = 12'h002;
   localparam logic [NUM_OPS-1:0] OP_XOR     = 12'h004;
   localparam logic [NUM_OPS-1:0] OP_NOR     = 12'h008;
   localparam logic [NUM_OPS-1:0] OP_NAND    = 12'h010;
   localparam logic [NUM_OPS-1:0] OP_XNOR    = 12'h020;
   localparam logic [NUM_OPS-1:0] OP_NOT     = 12'h040;
   localparam logic [NUM_OPS-1:0] OP_ADD     = 12'h080;
   localparam logic [NUM_OPS-1:0] OP_SUB     = 12'h100;
   localparam logic [NUM_OPS-1:0] OP_SHRIGHT = 12'h200;
   localparam logic [NUM_OPS-1:0] OP_SHLEFT  = 12'h400;
   localparam logic [NUM_OPS-1:0] OP_CLEAR   = 12'h800;

   localparam int unsigned OP_CLEAR_BIT = 11;

   // Flag bit positions within the 4-bit flag word
   localparam int unsigned FLAG_Z   = 0;
   localparam int unsigned FLAG_N   = 1;
   localparam int unsigned FLAG_CLR = 2;
   localparam int unsigned FLAG_ERR = 3;

   // Packed MSB-first, so err lands on bit 3 and z on bit 0
   typedef struct packed {
      logic err;
      logic clr;
      logic n;
      logic z;
   } alu_flags_t;

endpackage

// File: rtl/alu_out_fifo.sv
// ----------------------------------------------------------------------------
// alu_out_fifo
// In-order FIFO of DEPTH entries (DEPTH = 2 or 4), WIDTH bits each.
// Head entry is presented combinationally on dout_o; when empty, dout_o holds
// the last entry that was popped (0 after reset).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i, din_i   write request / data (ignored when full)
//   pop_i           read request (ignored when empty)
//   full_o, empty_o occupancy status, from registered state only
//   dout_o          head entry
// ----------------------------------------------------------------------------
module alu_out_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] dout_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] last_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign dout_o = empty_o ? last_q : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
         end
         // Remember the departing head so the output holds it once empty
         if (do_pop) begin
            last_q <= mem_q[rd_ptr_q];
         end
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
// Captures the ALU mux result, updates the accumulator fed back as operand A,
// generates {ERR,CLR,N,Z} flags and queues {data,flags} in an output FIFO.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid, in_ready            input handshake (in_ready = FIFO not full)
//   sel[11:0], res[W-1:0]         one-hot opcode and ALU mux result
//   acc[W-1:0]                    accumulator
//   out_valid, out_ready          output handshake
//   out_data[W-1:0], out_flags[3:0] head entry, flags = {ERR,CLR,N,Z}
//   err_sticky, err_clr           latched illegal-opcode flag and its clear
//   op_count[15:0], err_count[7:0] saturating counters, only when
//                                 ALU_RESULT_STATS_EN is defined
// ----------------------------------------------------------------------------
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [11:0]    sel,
   input  logic [W-1:0]   res,
   output logic [W-1:0]   acc,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_data,
   output logic [3:0]     out_flags,
`ifdef ALU_RESULT_STATS_EN
   output logic [15:0]    op_count,
   output logic [7:0]     err_count,
`endif
   output logic           err_sticky,
   input  logic           err_clr
);

   function automatic logic is_onehot(input logic [11:0] v);
      return (v != '0) && ((v & (v - 12'd1)) == '0);
   endfunction

   logic [W-1:0]   acc_q, acc_d;
   logic           err_q, err_d;
   logic           accept, legal;
   logic           fifo_full, fifo_empty;
   alu_flags_t     push_flags;
   logic [W-1:0]   push_data;
   logic [W+3:0]   fifo_head;

   assign legal  = is_onehot(sel);
   assign accept = in_valid && in_ready;

   always_comb begin
      push_flags = '0;
      push_data  = acc_q;
      acc_d      = acc_q;
      if (!legal) begin
         push_flags.err = 1'b1;
         push_flags.n   = acc_q[W-1];
         push_flags.z   = (acc_q == '0);
      end else if (sel[OP_CLEAR_BIT]) begin
         acc_d          = '0;
         push_data      = '0;
         push_flags.clr = 1'b1;
         push_flags.z   = 1'b1;
      end else begin
         acc_d          = res;
         push_data      = res;
         push_flags.n   = res[W-1];
         push_flags.z   = (res == '0);
      end
   end

   // Illegal accept takes priority over a same-cycle clear
   always_comb begin
      err_d = err_q;
      if (accept && !legal) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (accept) begin
            acc_q <= acc_d;
         end
         err_q <= err_d;
      end
   end

   alu_out_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (W + 4)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (accept),
      .din_i   ({push_data, push_flags}),
      .pop_i   (out_ready),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .dout_o  (fifo_head)
   );

   assign in_ready   = !fifo_full;
   assign out_valid  = !fifo_empty;
   assign out_data   = fifo_head[W+3:4];
   assign out_flags  = fifo_head[3:0];
   assign acc        = acc_q;
   assign err_sticky = err_q;

`ifdef ALU_RESULT_STATS_EN
   logic [15:0] op_cnt_q;
   logic [7:0]  err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else if (accept) begin
         if (op_cnt_q != '1) begin
            op_cnt_q <= op_cnt_q + 16'd1;
         end
         if (!legal && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign op_count  = op_cnt_q;
   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

   localparam int unsigned W     = 16;
   localparam int unsigned DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [11:0]   sel;
   logic [W-1:0]  res;
   logic [W-1:0]  acc;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [3:0]    out_flags;
   logic          err_sticky;
   logic          err_clr;
`ifdef ALU_RESULT_STATS_EN
   logic [15:0]   op_count;
   logic [7:0]    err_count;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   alu_result_stage #(
      .DEPTH (DEPTH),
      .W     (W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sel        (sel),
      .res        (res),
      .acc        (acc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_flags  (out_flags),
`ifdef ALU_RESULT_STATS_EN
      .op_count   (op_count),
      .err_count  (err_count),
`endif
      .err_sticky (err_sticky),
      .err_clr    (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle before sampling/driving
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [11:0] s, input logic [W-1:0] r);
      in_valid = v;
      sel      = s;
      res      = r;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      sel       = '0;
      res       = '0;
      out_ready = 1'b1;
      err_clr   = 1'b0;
      #2;
      chk("rst_acc",       32'(acc),        32'h0);
      chk("rst_out_valid", 32'(out_valid),  32'h0);
      chk("rst_out_data",  32'(out_data),   32'h0);
      chk("rst_out_flags", 32'(out_flags),  32'h0);
      chk("rst_err",       32'(err_sticky), 32'h0);
      #5 rst_n = 1'b1;
      tick();
      chk("rst_in_ready",  32'(in_ready),   32'h1);

      // ADD: one-cycle latency, clean flags
      drive(1'b1, 12'h080, 16'h1234);
      tick();
      drive(1'b0, 12'h000, 16'h0000);
      chk("add_valid", 32'(out_valid), 32'h1);
      chk("add_data",  32'(out_data),  32'h1234);
      chk("add_flags", 32'(out_flags), 32'h0);
      chk("add_acc",   32'(acc),       32'h1234);

      // SUB negative then NOR zero, in order
      drive(1'b1, 12'h100, 16'h8000);
      tick();
      chk("sub_data",  32'(out_data),  32'h8000);
      chk("sub_flags", 32'(out_flags), 32'h2);
      drive(1'b1, 12'h008, 16'h0000);
      tick();
      drive(1'b0, 12'h000, 16'h0000);
      chk("nor_data",  32'(out_data),  32'h0);
      chk("nor_flags", 32'(out_flags), 32'h1);
      chk("nor_acc",   32'(acc),       32'h0);
      tick();
      chk("empty_valid", 32'(out_valid), 32'h0);
      chk("empty_hold",  32'(out_flags), 32'h1);

      // Illegal multi-hot with acc = 0x00FF
      drive(1'b1, 12'h080, 16'h00FF);
      tick();
      drive(1'b1, 12'h003, 16'hABCD);
      tick();
      drive(1'b0, 12'h000, 16'h0000);
      chk("ill_data",  32'(out_data),   32'h00FF);
      chk("ill_flags", 32'(out_flags),  32'h8);
      chk("ill_err",   32'(err_sticky), 32'h1);
      chk("ill_acc",   32'(acc),        32'h00FF);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("errclr", 32'(err_sticky), 32'h0);

      // Zero sel together with err_clr: set wins
      drive(1'b1, 12'h000, 16'h5555);
      err_clr = 1'b1;
      tick();
      drive(1'b0, 12'h000, 16'h0000);
      chk("setwin_err",   32'(err_sticky), 32'h1);
      chk("setwin_data",  32'(out_data),   32'h00FF);
      chk("setwin_flags", 32'(out_flags),  32'h8);
      tick();
      err_clr = 1'b0;
      chk("setwin_clr", 32'(err_sticky), 32'h0);
      tick();

      // Backpressure: DEPTH+1 accepts attempted
      out_ready = 1'b0;
      drive(1'b1, 12'h080, 16'h0001);
      tick();
      chk("bp_ready1", 32'(in_ready), 32'h1);
      drive(1'b1, 12'h080, 16'h0002);
      tick();
      chk("bp_full",   32'(in_ready),  32'h0);
      chk("bp_head",   32'(out_data),  32'h0001);
      drive(1'b1, 12'h080, 16'h0003);
      tick();
      drive(1'b0, 12'h000, 16'h0000);
      chk("bp_block_acc", 32'(acc),      32'h0002);
      chk("bp_still_full", 32'(in_ready), 32'h0);
      out_ready = 1'b1;
      tick();
      chk("bp_pop1_ready", 32'(in_ready), 32'h1);
      chk("bp_pop1_data",  32'(out_data), 32'h0002);
      tick();
      chk("bp_drained",    32'(out_valid), 32'h0);
      chk("bp_hold",       32'(out_data),  32'h0002);

      // CLEAR ignores res
      drive(1'b1, 12'h800, 16'hFFFF);
      tick();
      drive(1'b0, 12'h000, 16'h0000);
      chk("clr_acc",   32'(acc),       32'h0);
      chk("clr_data",  32'(out_data),  32'h0);
      chk("clr_flags", 32'(out_flags), 32'h5);
      tick();

      // Reset with two entries buffered
      out_ready = 1'b0;
      drive(1'b1, 12'h080, 16'h0011);
      tick();
      drive(1'b1, 12'h080, 16'h0022);
      tick();
      drive(1'b0, 12'h000, 16'h0000);
      chk("pre_rst_valid", 32'(out_valid), 32'h1);
`ifdef ALU_RESULT_STATS_EN
      chk("op_count",  32'(op_count),  32'd11);
      chk("err_count", 32'(err_count), 32'd2);
`endif
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_acc",   32'(acc),       32'h0);
      chk("mid_rst_data",  32'(out_data),  32'h0);
`ifdef ALU_RESULT_STATS_EN
      chk("mid_rst_opcnt", 32'(op_count),  32'h0);
`endif
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'h0);
      chk("post_rst_ready", 32'(in_ready),  32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, output buffer entries (legal values 2 or 4).
REQ-002 The block SHALL have parameter W, default 16, datapath width.
REQ-003 Ports SHALL be: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-004 Ports SHALL be: in_valid  in  1  mux result valid; in_ready  out  1  stage can accept.
REQ-005 Ports SHALL be: sel  in  12  one-hot opcode that produced res; res  in  W  ALU mux output.
REQ-006 Ports SHALL be: acc  out  W  accumulator, fed back as ALU operand A.
REQ-007 Ports SHALL be: out_valid  out  1; out_ready  in  1; out_data  out  W; out_flags  out  4  {ERR,CLR,N,Z}.
REQ-008 Ports SHALL be: err_sticky  out  1  latched illegal-opcode indicator; err_clr  in  1  clears err_sticky.

Function
REQ-009 Transfer on input SHALL occur when in_valid && in_ready at a rising clk edge.
REQ-010 in_ready SHALL equal "buffer not full", registered-state only, with no combinational path from out_ready.
REQ-011 Legal sel: exactly one bit set, from the 12 one-hot opcodes (AND..SHLEFT, bit 11 = CLEAR).
REQ-012 Accepted legal non-CLEAR op: acc <= res, push {res, ERR=0, CLR=0, N=res[W-1], Z=(res==0)}.
REQ-013 Accepted CLEAR (sel[11]): acc <= 0, push {0, ERR=0, CLR=1, N=0, Z=1}; res is ignored.
REQ-014 Accepted illegal sel (zero or multi-hot): acc unchanged, push {acc, ERR=1, CLR=0, N/Z of acc}, err_sticky <= 1.
REQ-015 acc SHALL update in the same edge as the accept; latency from accept to out_valid SHALL be 1 cycle when the buffer is empty.
REQ-016 Buffer SHALL be a FIFO of DEPTH entries, in-order, with out_data/out_flags driven from the head entry.
REQ-017 Pop SHALL occur when out_valid && out_ready; out_valid = buffer not empty.
REQ-018 Simultaneous push and pop when partially full: count unchanged, both take effect.
REQ-019 When full, in_ready = 0; a pop frees the slot, and in_ready rises on the following cycle.
REQ-020 When empty, out_valid = 0 and out_data/out_flags SHALL hold their last values (no X).
REQ-021 err_clr and an illegal accept in the same cycle: set wins, err_sticky = 1.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-023 On rst_n low, immediately (asynchronously): acc=0, buffer empty, out_valid=0, in_ready=1 after release, out_data=0, out_flags=0, err_sticky=0.
REQ-024 Reset mid-transfer SHALL discard all buffered entries; no partial entry survives.

Configuration
REQ-025 With ALU_RESULT_STATS_EN defined: add outputs op_count (16) and err_count (8), both reset to 0.
REQ-026 op_count SHALL increment per accepted transfer; err_count SHALL increment per illegal accept; both saturate at all-ones.
REQ-027 Without ALU_RESULT_STATS_EN, these ports and their counters SHALL NOT exist.

Structure
REQ-028 Package alu_pkg SHALL hold the 12 one-hot opcode constants, flag bit indices (Z=0,N=1,CLR=2,ERR=3), and the flags struct typedef.
REQ-029 The FIFO SHALL be sub-module alu_out_fifo (DEPTH, width W+4); flag generation and the one-hot check stay in alu_result_stage.

Verification
REQ-030 ADD sel=0x080, res=0x1234, out_ready=1 -> next cycle out_valid=1, out_data=0x1234, flags=0000, acc=0x1234.
REQ-031 SUB sel=0x100, res=0x8000 then NOR res=0x0000 -> flags N=1 then Z=1, in order.
REQ-032 sel=0x003, acc=0x00FF -> out_data=0x00FF, ERR=1, err_sticky=1, acc unchanged; then err_clr -> err_sticky=0.
REQ-033 out_ready=0 with DEPTH+1 back-to-back accepts attempted -> in_ready=0 after DEPTH; release -> all DEPTH entries drain in order, in_ready returns 1 cycle after the first pop.
REQ-034 CLEAR sel=0x800 with res=0xFFFF -> acc=0, out_data=0, flags CLR=1, Z=1.
REQ-035 rst_n asserted with 2 entries buffered -> out_valid=0 and acc=0 immediately; with stats enabled, op_count=0.
